// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: FSM states, decoded instruction, memory op codes.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   // Decoded instruction as delivered by the decoder; only the memory fields matter here.
   typedef struct packed {
      logic lb;
      logic lh;
      logic lw;
      logic lbu;
      logic lhu;
      logic sb;
      logic sh;
      logic sw;
   } instructions;

   // Compact memory operation code used between the stage and the lane aligner.
   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LB   = 4'd1,
      OP_LH   = 4'd2,
      OP_LW   = 4'd3,
      OP_LBU  = 4'd4,
      OP_LHU  = 4'd5,
      OP_SB   = 4'd6,
      OP_SH   = 4'd7,
      OP_SW   = 4'd8
   } mem_op_t;

   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

   // Collapse the one-hot decode to an op code; anything without a memory bit is OP_NONE.
   function automatic mem_op_t decode_op(input instructions ins);
      mem_op_t op;
      op = OP_NONE;
      if      (ins.lb)  op = OP_LB;
      else if (ins.lh)  op = OP_LH;
      else if (ins.lw)  op = OP_LW;
      else if (ins.lbu) op = OP_LBU;
      else if (ins.lhu) op = OP_LHU;
      else if (ins.sb)  op = OP_SB;
      else if (ins.sh)  op = OP_SH;
      else if (ins.sw)  op = OP_SW;
      return op;
   endfunction

   function automatic logic op_is_store(input mem_op_t op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/mem_stage_lane_align.sv
// Byte-lane steering: store data replication/strobes, load extraction/extension, misalignment.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module mem_lane_align
   import mem_stage_pkg::*;
(
   input  mem_op_t     i_op,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_rs2,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_wstrb,
   output logic [31:0] o_load,
   output logic        o_misaligned
);

   // Read word shifted so the addressed byte/halfword sits at bit 0.
   logic [15:0] w_lane;
   assign w_lane = 16'(i_rdata >> {i_addr_lo, 3'b000});

   // Per-op lane selection; loads drive no strobes, stores produce no load value.
   always_comb begin
      o_wdata      = 32'd0;
      o_wstrb      = 4'd0;
      o_load       = 32'd0;
      o_misaligned = 1'b0;
      case (i_op)
         OP_LB:  o_load = {{24{w_lane[7]}}, w_lane[7:0]};
         OP_LBU: o_load = {24'd0, w_lane[7:0]};
         OP_LH: begin
            o_load       = {{16{w_lane[15]}}, w_lane};
            o_misaligned = i_addr_lo[0];
         end
         OP_LHU: begin
            o_load       = {16'd0, w_lane};
            o_misaligned = i_addr_lo[0];
         end
         OP_LW: begin
            o_load       = i_rdata;
            o_misaligned = |i_addr_lo;
         end
         OP_SB: begin
            o_wdata = {4{i_rs2[7:0]}};
            o_wstrb = 4'b0001 << i_addr_lo;
         end
         OP_SH: begin
            o_wdata      = {2{i_rs2[15:0]}};
            o_wstrb      = 4'b0011 << i_addr_lo;
            o_misaligned = i_addr_lo[0];
         end
         OP_SW: begin
            o_wdata      = i_rs2;
            o_wstrb      = 4'b1111;
            o_misaligned = |i_addr_lo;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory stage after the ALU: one outstanding req/ack data access, else forwards the ALU result.
// Latency: 1 cycle for non-memory/misaligned ops, 2+k cycles for an access acked k cycles after req.
// Backpressure: start ignored outside IDLE; mem_req held until ack or timeout, no queueing.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_enabled,
   input  instructions i_instr,
   input  logic [31:0] i_alu_result,
   input  logic [31:0] i_rs2_value,
   output logic        o_completed,
   output logic [31:0] o_result,
   output logic        o_misaligned,
   output logic        o_bus_error,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_wstrb,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata
);

   localparam logic [31:0] LP_TMO = 32'(TIMEOUT_CYCLES);

   mem_state_t  r_state;
   mem_op_t     r_op;
   logic [1:0]  r_addr_lo;
   logic [31:0] r_cnt;

   mem_op_t     w_op_in;
   mem_op_t     w_op;
   logic [1:0]  w_addr_lo;
   logic [31:0] w_wdata;
   logic [3:0]  w_wstrb;
   logic [31:0] w_load;
   logic        w_mis;

   assign w_op_in = decode_op(i_instr);

   // In IDLE the aligner looks at the live request (strobes, misalignment);
   // afterwards it looks at the latched op so the ack-cycle rdata is extended correctly.
   assign w_op      = (r_state == IDLE) ? w_op_in : r_op;
   assign w_addr_lo = (r_state == IDLE) ? i_alu_result[1:0] : r_addr_lo;

   mem_lane_align u_align (
      .i_op         (w_op),
      .i_addr_lo    (w_addr_lo),
      .i_rs2        (i_rs2_value),
      .i_rdata      (i_mem_rdata),
      .o_wdata      (w_wdata),
      .o_wstrb      (w_wstrb),
      .o_load       (w_load),
      .o_misaligned (w_mis)
   );

   // Stage FSM with all outputs registered; completed is a single-cycle pulse on entry to DONE.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state      <= IDLE;
         r_op         <= OP_NONE;
         r_addr_lo    <= 2'd0;
         r_cnt        <= 32'd0;
         o_completed  <= 1'b0;
         o_result     <= 32'd0;
         o_misaligned <= 1'b0;
         o_bus_error  <= 1'b0;
         o_mem_req    <= 1'b0;
         o_mem_we     <= 1'b0;
         o_mem_addr   <= 32'd0;
         o_mem_wdata  <= 32'd0;
         o_mem_wstrb  <= 4'd0;
      end else begin
         o_completed <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_enabled) begin
                  r_op         <= w_op_in;
                  r_addr_lo    <= i_alu_result[1:0];
                  r_cnt        <= 32'd0;
                  o_misaligned <= 1'b0;
                  o_bus_error  <= 1'b0;
                  if (w_op_in == OP_NONE) begin
                     o_result    <= i_alu_result;
                     o_completed <= 1'b1;
                     r_state     <= DONE;
                  end else if (w_mis) begin
                     // Rejected before touching the bus.
                     o_misaligned <= 1'b1;
                     o_result     <= 32'd0;
                     o_completed  <= 1'b1;
                     r_state      <= DONE;
                  end else begin
                     o_mem_req   <= 1'b1;
                     o_mem_we    <= op_is_store(w_op_in);
                     o_mem_addr  <= {i_alu_result[31:2], 2'b00};
                     o_mem_wdata <= w_wdata;
                     o_mem_wstrb <= w_wstrb;
                     r_state     <= REQ;
                  end
               end
            end
            REQ: begin
               // An ack in the final allowed cycle still wins over the timeout.
               if (i_mem_ack) begin
                  o_mem_req   <= 1'b0;
                  o_mem_we    <= 1'b0;
                  o_result    <= op_is_store(r_op) ? 32'd0 : w_load;
                  o_completed <= 1'b1;
                  r_cnt       <= 32'd0;
                  r_state     <= DONE;
               end else if ((LP_TMO != 32'd0) && (r_cnt == LP_TMO - 32'd1)) begin
                  o_mem_req   <= 1'b0;
                  o_mem_we    <= 1'b0;
                  o_bus_error <= 1'b1;
                  o_result    <= 32'd0;
                  o_completed <= 1'b1;
                  r_cnt       <= 32'd0;
                  r_state     <= DONE;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
